// File: rtl/line_memory.sv
// -----------------------------------------------------------------------------
// line_memory
//
// Block-granular backing store below the data cache. Every request moves one
// whole line after a fixed access latency, acting as the responder end of the
// cache's mem_ready / is_output_valid handshake.
//
// Parameters:
//   BLOCK_SIZE  line size in bytes (data ports are BLOCK_SIZE*8 bits)
//   NUM_LINES   storage depth in lines, power of two
//   LATENCY     cycles from acceptance to completion (>= 1)
//
// Ports:
//   clk              single clock, rising edge
//   reset            asynchronous active-low reset
//   is_input_valid   request present this cycle
//   addr             line address (byte address >> CLOG2(BLOCK_SIZE))
//   mem_read         read request
//   mem_write        write request (wins over mem_read when both are set)
//   din              write line data
//   is_output_valid  dout holds read data this cycle
//   dout             read line data, zero outside the read response cycle
//   mem_ready        registered, high only while idle
//   num_reads        completed reads   (only with LINE_MEM_STATS_EN)
//   num_writes       completed writes  (only with LINE_MEM_STATS_EN)
//
// Optional feature: define LINE_MEM_STATS_EN to add the saturating
// num_reads / num_writes completion counters.
// -----------------------------------------------------------------------------
module line_memory #(
   parameter int unsigned BLOCK_SIZE = 16,
   parameter int unsigned NUM_LINES  = 256,
   parameter int unsigned LATENCY    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    is_input_valid,
   input  logic [31:0]             addr,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic [BLOCK_SIZE*8-1:0] din,
   output logic                    is_output_valid,
   output logic [BLOCK_SIZE*8-1:0] dout,
   output logic                    mem_ready
`ifdef LINE_MEM_STATS_EN
   ,
   output logic [31:0]             num_reads,
   output logic [31:0]             num_writes
`endif
);

   localparam int unsigned DW   = BLOCK_SIZE * 8;
   localparam int unsigned AW   = $clog2(NUM_LINES);
   localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StResp
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            is_write_q, is_write_d;
   logic [DW-1:0]   din_q, din_d;
   logic            mem_ready_q, mem_ready_d;
   logic            valid_q, valid_d;
   logic [DW-1:0]   dout_q, dout_d;

   logic [DW-1:0]   mem [NUM_LINES];

   logic            accept;
   logic            access;
   logic            wr_en;

   // Upper address bits are deliberately dropped so addresses wrap.
   logic            unused_addr;
   assign unused_addr = ^addr[31:AW];

   assign accept = is_input_valid && (mem_read || mem_write);
   // The access happens on the edge that leaves BUSY for RESP.
   assign access = (state_q == StBusy) && (cnt_q == '0);
   assign wr_en  = access && is_write_q;

   // --------------------------------------------------------------------------
   // Next-state and output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      is_write_d = is_write_q;
      din_d      = din_q;
      valid_d    = 1'b0;
      dout_d     = '0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d     = addr[AW-1:0];
               is_write_d = mem_write;
               din_d      = din;
               cnt_d      = CntW'(LATENCY - 1);
               state_d    = StBusy;
            end
         end
         StBusy: begin
            if (cnt_q == '0) begin
               state_d = StResp;
               if (!is_write_q) begin
                  valid_d = 1'b1;
                  dout_d  = mem[addr_q];
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      mem_ready_d = (state_d == StIdle);
   end

   // --------------------------------------------------------------------------
   // Control and request registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         addr_q      <= '0;
         is_write_q  <= 1'b0;
         din_q       <= '0;
         mem_ready_q <= 1'b1;
         valid_q     <= 1'b0;
         dout_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         is_write_q  <= is_write_d;
         din_q       <= din_d;
         mem_ready_q <= mem_ready_d;
         valid_q     <= valid_d;
         dout_q      <= dout_d;
      end
   end

   // --------------------------------------------------------------------------
   // Line array: never reset. wr_en is derived from reset state, so a reset
   // during BUSY abandons the write before it can commit.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr_q] <= din_q;
      end
   end

   assign mem_ready       = mem_ready_q;
   assign is_output_valid = valid_q;
   assign dout            = dout_q;

`ifdef LINE_MEM_STATS_EN
   // --------------------------------------------------------------------------
   // Completion counters, bumped on the edge entering RESP, saturating.
   // --------------------------------------------------------------------------
   logic [31:0] num_reads_q, num_writes_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num_reads_q  <= '0;
         num_writes_q <= '0;
      end else if (access) begin
         if (is_write_q) begin
            if (num_writes_q != 32'hFFFF_FFFF) begin
               num_writes_q <= num_writes_q + 32'd1;
            end
         end else begin
            if (num_reads_q != 32'hFFFF_FFFF) begin
               num_reads_q <= num_reads_q + 32'd1;
            end
         end
      end
   end

   assign num_reads  = num_reads_q;
   assign num_writes = num_writes_q;
`endif

endmodule

// File: tb/tb_line_memory.sv
// -----------------------------------------------------------------------------
// tb_line_memory
//
// Self-checking bench for line_memory. A reference model keeps the line
// contents in an associative array indexed by (addr mod NUM_LINES) and derives
// the expected handshake timeline from LATENCY alone.
// -----------------------------------------------------------------------------
module tb_line_memory;

   localparam int unsigned BS  = 16;
   localparam int unsigned NL  = 256;
   localparam int unsigned LAT = 4;
   localparam int unsigned DW  = BS * 8;

   logic          clk;
   logic          reset;
   logic          is_input_valid;
   logic [31:0]   addr;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] din;
   logic          is_output_valid;
   logic [DW-1:0] dout;
   logic          mem_ready;
`ifdef LINE_MEM_STATS_EN
   logic [31:0]   num_reads;
   logic [31:0]   num_writes;
`endif

   int n_checks = 0;
   int n_bad    = 0;

   logic [DW-1:0] ref_mem [int unsigned];
   int unsigned   written_lines [$];

   line_memory #(
      .BLOCK_SIZE (BS),
      .NUM_LINES  (NL),
      .LATENCY    (LAT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .is_input_valid  (is_input_valid),
      .addr            (addr),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .din             (din),
      .is_output_valid (is_output_valid),
      .dout            (dout),
      .mem_ready       (mem_ready)
`ifdef LINE_MEM_STATS_EN
      ,
      .num_reads       (num_reads),
      .num_writes      (num_writes)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      while (mem_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("ready_wait", DW'(mem_ready), DW'(1));
   endtask

   task automatic model_write(input int unsigned line, input logic [DW-1:0] d);
      if (!ref_mem.exists(line)) written_lines.push_back(line);
      ref_mem[line] = d;
   endtask

   // Issue one request and follow it through BUSY/RESP back to IDLE.
   // noise: 0 = random junk on the inputs while not idle,
   //        1 = a write of fresh data to the same line while not idle.
   task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [DW-1:0] d, input bit noise);
      int unsigned   line;
      logic [DW-1:0] exp_line;
      bit            is_rd;
      line = a % NL;
      wait_ready();
      is_input_valid = 1'b1;
      mem_read       = rd;
      mem_write      = wr;
      addr           = a;
      din            = d;
      @(negedge clk);
      if (!rd && !wr) begin
         check_eq("noop_ready", DW'(mem_ready), DW'(1));
         check_eq("noop_valid", DW'(is_output_valid), DW'(0));
         is_input_valid = 1'b0;
         return;
      end
      is_rd    = !wr;
      exp_line = (is_rd && ref_mem.exists(line)) ? ref_mem[line] : '0;
      for (int k = 0; k <= int'(LAT) + 1; k++) begin
         check_eq($sformatf("ready_k%0d", k), DW'(mem_ready),
                  DW'(k == int'(LAT) + 1));
         check_eq($sformatf("valid_k%0d", k), DW'(is_output_valid),
                  DW'(is_rd && k == int'(LAT)));
         check_eq($sformatf("dout_k%0d", k), dout,
                  (is_rd && k == int'(LAT)) ? exp_line : '0);
         if (k <= int'(LAT)) begin
            if (noise) begin
               is_input_valid = 1'b1;
               mem_read       = 1'b0;
               mem_write      = 1'b1;
               addr           = a;
               din            = rand_line();
            end else begin
               is_input_valid = 1'($urandom());
               mem_read       = 1'($urandom());
               mem_write      = 1'($urandom());
               addr           = $urandom();
               din            = rand_line();
            end
            @(negedge clk);
         end else begin
            is_input_valid = 1'b0;
         end
      end
      if (wr) model_write(line, d);
   endtask

   initial begin : stim
      logic [DW-1:0] pat_a;
      logic [DW-1:0] pat_b;
      logic [DW-1:0] line0;
      int unsigned   line;
      int            r;

      reset          = 1'b0;
      is_input_valid = 1'b0;
      addr           = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      din            = '0;

      // Reset values
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("rst_ready", DW'(mem_ready), DW'(1));
      check_eq("rst_valid", DW'(is_output_valid), DW'(0));
      check_eq("rst_dout", dout, '0);
`ifdef LINE_MEM_STATS_EN
      check_eq("rst_nreads", DW'(num_reads), '0);
      check_eq("rst_nwrites", DW'(num_writes), '0);
`endif

      // Write then read the same line
      line0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
      do_req(1'b0, 1'b1, 32'd5, line0, 1'b0);
      do_req(1'b1, 1'b0, 32'd5, '0, 1'b0);

      // Address wrap: 0x105 aliases line 5
      pat_a = rand_line();
      do_req(1'b0, 1'b1, 32'h105, pat_a, 1'b0);
      do_req(1'b1, 1'b0, 32'd5, '0, 1'b0);

      // Writes pulsed at the same line during a read are ignored
      do_req(1'b1, 1'b0, 32'd5, '0, 1'b1);
      do_req(1'b1, 1'b0, 32'd5, '0, 1'b0);

      // Request with no operation bit is ignored
      do_req(1'b0, 1'b0, 32'd9, rand_line(), 1'b0);
      @(negedge clk);
      check_eq("noop_ready_later", DW'(mem_ready), DW'(1));

      // Both bits set: the write wins
      pat_b = rand_line();
      do_req(1'b1, 1'b1, 32'd12, pat_b, 1'b0);
      do_req(1'b1, 1'b0, 32'd12, '0, 1'b0);

      // Reset mid-write abandons the write
      do_req(1'b0, 1'b1, 32'd7, pat_a, 1'b0);
      wait_ready();
      is_input_valid = 1'b1;
      mem_read       = 1'b0;
      mem_write      = 1'b1;
      addr           = 32'd7;
      din            = pat_b;
      @(negedge clk);
      is_input_valid = 1'b0;
      check_eq("midrst_busy", DW'(mem_ready), DW'(0));
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("midrst_ready", DW'(mem_ready), DW'(1));
      check_eq("midrst_valid", DW'(is_output_valid), DW'(0));
      check_eq("midrst_dout", dout, '0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("postrst_ready", DW'(mem_ready), DW'(1));
      do_req(1'b1, 1'b0, 32'd7, '0, 1'b0);

`ifdef LINE_MEM_STATS_EN
      begin : stats
         bit          ops_wr [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
         int          acc [5];
         int          cyc;
         int          n;
         logic [31:0] r0;
         logic [31:0] w0;
         r0  = num_reads;
         w0  = num_writes;
         cyc = 0;
         for (int i = 0; i < 5; i++) begin
            n = 0;
            while (mem_ready !== 1'b1 && n < 20) begin
               @(negedge clk);
               cyc++;
               n++;
            end
            check_eq("stats_ready", DW'(mem_ready), DW'(1));
            is_input_valid = 1'b1;
            mem_read       = !ops_wr[i];
            mem_write      = ops_wr[i];
            addr           = 32'd20;
            din            = rand_line();
            if (ops_wr[i]) model_write(20, din);
            acc[i] = cyc;
            @(negedge clk);
            cyc++;
            if (i == 4) is_input_valid = 1'b0;
         end
         wait_ready();
         check_eq("stats_nreads", DW'(num_reads - r0), DW'(3));
         check_eq("stats_nwrites", DW'(num_writes - w0), DW'(2));
         // Consecutive accepts are separated by exactly LAT+1 not-ready cycles.
         for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("stats_gap%0d", i), DW'(acc[i+1] - acc[i] - 1),
                     DW'(LAT + 1));
         end
      end
`endif

      // Randomized mix against the model
      for (int it = 0; it < 40; it++) begin
         r = int'($urandom_range(0, 9));
         if (written_lines.size() == 0 || r < 4) begin
            line = $urandom_range(0, 15);
            do_req(1'($urandom()), 1'b1, ($urandom() & 32'hFFFF_FF00) | line,
                   rand_line(), 1'b0);
         end else if (r == 4) begin
            do_req(1'b0, 1'b0, $urandom(), rand_line(), 1'b0);
         end else begin
            line = written_lines[$urandom_range(0, written_lines.size() - 1)];
            do_req(1'b1, 1'b0, ($urandom() & 32'hFFFF_FF00) | line, '0, 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
